// File: rtl/adapter_pkg.sv
// Shared definitions for the BRAM line adapter: default geometry,
// the clogb2 helper and the line reader state encoding.
package adapter_pkg;

    localparam int unsigned WORD_W_DEF     = 32;
    localparam int unsigned LINE_WORDS_DEF = 36;

    // Bits needed to index 'value' distinct items, never less than 1.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        FILL,
        STREAM,
        DONE
    } reader_state_t;

endpackage

// File: rtl/bram_line_word_sel.sv
// Combinational word selector: picks one WORD_W slice out of a wide
// BRAM line. Out-of-range selects return zero.
module bram_line_word_sel
    import adapter_pkg::*;
#(
    parameter int unsigned WORD_W     = WORD_W_DEF,
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
    parameter int unsigned LINE_W     = WORD_W * LINE_WORDS,
    parameter int unsigned PTR_W      = clogb2(LINE_WORDS)
) (
    input  logic [LINE_W-1:0] line,
    input  logic [PTR_W-1:0]  sel,
    output logic [WORD_W-1:0] word
);

    // Explicit compare-per-word mux keeps every slice index in range.
    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            if (sel == PTR_W'(i)) begin
                word = line[i*WORD_W +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/bram_line_axis_reader.sv
// Reads BRAM lines start_index..bound_index (inclusive) and serializes
// each line word 0 first onto an AXI-Stream master port.
// Optional macro BRAM_LINE_PREFETCH_EN adds a shadow line buffer so the
// next line is fetched while the current one streams (no inter-line bubble).
module bram_line_axis_reader
    import adapter_pkg::*;
#(
    parameter int unsigned WORD_W     = WORD_W_DEF,
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
    parameter int unsigned LINE_W     = WORD_W * LINE_WORDS,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned PTR_W      = clogb2(LINE_WORDS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_index,
    input  logic [ADDR_W-1:0]   bound_index,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                bram_en,
    output logic [ADDR_W-1:0]   bram_addr,
    input  logic [LINE_W-1:0]   bram_dout,
    output logic                m_axis_tvalid,
    output logic [WORD_W-1:0]   m_axis_tdata,
    output logic [WORD_W/8-1:0] m_axis_tstrb,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LINE_WORDS - 1);

    reader_state_t     state, state_next;
    logic [ADDR_W-1:0] cur_idx, bnd_idx, next_idx;
    logic [PTR_W-1:0]  ptr;
    logic [LINE_W-1:0] line_buf;
    logic              err_q;
    logic              accept, reject;
    logic              beat, line_end, last_line, swap;
    logic [WORD_W-1:0] word;

    assign next_idx  = cur_idx + ADDR_W'(1);
    assign last_line = (cur_idx == bnd_idx);
    assign beat      = (state == STREAM) && m_axis_tready;
    assign line_end  = beat && (ptr == LAST_PTR);

`ifdef BRAM_LINE_PREFETCH_EN
    logic [LINE_W-1:0] shadow_buf;
    logic              shadow_valid;
    logic              pf_req;
    logic              pf_capture;

    // Line change without leaving STREAM when the next line is already shadowed.
    assign swap = line_end && !last_line && shadow_valid;
`else
    assign swap = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and command accept/reject decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (bound_index < start_index) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE:   state_next = FILL;
            FILL:    state_next = STREAM;
            STREAM: begin
                // End test is made on cur_idx before any increment, so a
                // bound of all-ones finishes without wrapping.
                if (line_end) begin
                    if (last_line) begin
                        state_next = DONE;
                    end else if (!swap) begin
                        state_next = ISSUE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Line index, word pointer and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_idx <= '0;
            bnd_idx <= '0;
            ptr     <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= reject;
            if (accept) begin
                cur_idx <= start_index;
                bnd_idx <= bound_index;
            end
            if (state == FILL) begin
                ptr <= '0;
            end else if (beat) begin
                if (line_end) begin
                    ptr <= '0;
                    if (!last_line) begin
                        cur_idx <= next_idx;
                    end
                end else begin
                    ptr <= ptr + PTR_W'(1);
                end
            end
        end
    end

    // Line buffer load; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            line_buf <= bram_dout;
`ifdef BRAM_LINE_PREFETCH_EN
        end else if (swap) begin
            line_buf <= shadow_buf;
`endif
        end
    end

`ifdef BRAM_LINE_PREFETCH_EN
    // Prefetch control: request the following line on every entry into a
    // line that is not the last, capture it one cycle after the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            pf_req       <= 1'b0;
            pf_capture   <= 1'b0;
            shadow_valid <= 1'b0;
        end else begin
            pf_req     <= ((state == FILL) && !last_line) ||
                          (swap && (next_idx != bnd_idx));
            pf_capture <= pf_req;
            if (pf_capture) begin
                shadow_valid <= 1'b1;
            end else if (line_end) begin
                shadow_valid <= 1'b0;
            end
        end
    end

    // Shadow buffer capture of prefetched BRAM data.
    always_ff @(posedge clk) begin
        if (pf_capture) begin
            shadow_buf <= bram_dout;
        end
    end

    assign bram_en   = (state == ISSUE) || pf_req;
    assign bram_addr = pf_req ? next_idx : cur_idx;
`else
    assign bram_en   = (state == ISSUE);
    assign bram_addr = cur_idx;
`endif

    bram_line_word_sel #(
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS),
        .LINE_W     (LINE_W),
        .PTR_W      (PTR_W)
    ) u_word_sel (
        .line (line_buf),
        .sel  (ptr),
        .word (word)
    );

    assign busy          = (state == ISSUE) || (state == FILL) || (state == STREAM);
    assign done          = (state == DONE);
    assign err           = err_q;
    assign m_axis_tvalid = (state == STREAM);
    assign m_axis_tdata  = word;
    assign m_axis_tstrb  = '1;
    assign m_axis_tlast  = (state == STREAM) && (ptr == LAST_PTR) && last_line;

endmodule

// File: tb/tb_bram_line_axis_reader.sv
// Self-checking bench for bram_line_axis_reader: BRAM model, expected-beat
// queue filled at command time and drained by a stream monitor.
module tb_bram_line_axis_reader;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_WORDS = 36;
    localparam int unsigned LINE_W     = WORD_W * LINE_WORDS;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned PTR_W      = 6;
`ifdef BRAM_LINE_PREFETCH_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 3;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   start_index = '0;
    logic [ADDR_W-1:0]   bound_index = '0;
    logic                busy, done, err, bram_en;
    logic [ADDR_W-1:0]   bram_addr;
    logic [LINE_W-1:0]   bram_dout;
    logic                m_axis_tvalid;
    logic [WORD_W-1:0]   m_axis_tdata;
    logic [WORD_W/8-1:0] m_axis_tstrb;
    logic                m_axis_tlast;
    logic                m_axis_tready = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_beats, n_valid, n_done, n_err, n_busy, n_en, n_last;
    int first_valid_cyc, done_cyc, start_cyc;
    int beat_cyc[$];
    logic [WORD_W:0] sb[$];
    logic [WORD_W:0] mon_exp;
    logic            prev_stall = 1'b0;
    logic [WORD_W-1:0] prev_data;
    logic            prev_last;
    bit              rand_ready = 1'b0;

    bram_line_axis_reader #(
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS),
        .LINE_W     (LINE_W),
        .ADDR_W     (ADDR_W),
        .PTR_W      (PTR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .start_index   (start_index),
        .bound_index   (bound_index),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .bram_en       (bram_en),
        .bram_addr     (bram_addr),
        .bram_dout     (bram_dout),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word k of line l: {l[7:0], 4'h0, l[11:8], k[15:0]} -> line 5 word k = 0x0500_0000+k.
    function automatic logic [WORD_W-1:0] word_of(input int l, input int k);
        logic [11:0] a;
        logic [15:0] kk;
        a  = l[11:0];
        kk = k[15:0];
        return {a[7:0], 4'h0, a[11:8], kk};
    endfunction

    function automatic logic [LINE_W-1:0] line_data(input int l);
        logic [LINE_W-1:0] r;
        for (int k = 0; k < LINE_WORDS; k++) r[k*WORD_W +: WORD_W] = word_of(l, k);
        return r;
    endfunction

    // BRAM read port model, 1-cycle latency, output held when not enabled.
    always @(posedge clk) begin
        if (bram_en) bram_dout <= line_data(int'(bram_addr));
    end

    // Stream monitor: scoreboard pops, stall stability and event counters.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%0b data=%h last=%0b, expected valid=1 data=%h last=%0b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                end
            end
            if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_axis_tvalid) n_valid++;
            if (m_axis_tvalid && m_axis_tready) begin
                n_beats++;
                beat_cyc.push_back(cyc);
                if (m_axis_tlast) n_last++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL beat_unexpected: got data=%h last=%0b, expected no beat", m_axis_tdata, m_axis_tlast);
                end else begin
                    mon_exp = sb.pop_front();
                    if ({m_axis_tlast, m_axis_tdata} !== mon_exp) begin
                        failures++;
                        $display("FAIL beat_%0d: got last=%0b data=%h, expected last=%0b data=%h",
                                 n_beats, m_axis_tlast, m_axis_tdata, mon_exp[WORD_W], mon_exp[WORD_W-1:0]);
                    end
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (err) n_err++;
            if (busy) n_busy++;
            if (bram_en) n_en++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_stats();
        n_beats = 0; n_valid = 0; n_done = 0; n_err = 0; n_busy = 0; n_en = 0; n_last = 0;
        first_valid_cyc = -1; done_cyc = -1;
        beat_cyc.delete();
    endtask

    task automatic pulse_start(input int s, input int b, input bit push);
        @(posedge clk); #1;
        start = 1'b1;
        start_index = ADDR_W'(s);
        bound_index = ADDR_W'(b);
        if (push && b >= s)
            for (int l = s; l <= b; l++)
                for (int k = 0; k < LINE_WORDS; k++)
                    sb.push_back({(l == b && k == LINE_WORDS - 1), word_of(l, k)});
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
            if (n_done > 0) begin
                ok = 1'b1;
                break;
            end
        end
        m_axis_tready = 1'b1;
    endtask

    function automatic int span();
        return (beat_cyc.size() > 0) ? beat_cyc[beat_cyc.size()-1] - beat_cyc[0] : -1;
    endfunction

    task automatic test_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, err, bram_en, m_axis_tvalid, m_axis_tlast} !== 6'b0 || bram_addr !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b en=%0b valid=%0b last=%0b addr=%h, expected all 0",
                     busy, done, err, bram_en, m_axis_tvalid, m_axis_tlast, bram_addr);
        end
        checks++;
        if (m_axis_tstrb !== 4'hF) begin
            failures++;
            $display("FAIL reset_tstrb: got %h expected f", m_axis_tstrb);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_line();
        bit ok;
        clear_stats();
        pulse_start(5, 5, 1'b1);
        wait_done(ok);
        repeat (3) @(posedge clk);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_done_timeout: got no done, expected done"); end
        checks++;
        if (n_beats != 36) begin failures++; $display("FAIL single_beats: got %0d expected 36", n_beats); end
        checks++;
        if (first_valid_cyc - start_cyc != 2) begin
            failures++; $display("FAIL single_latency: got %0d expected 2", first_valid_cyc - start_cyc);
        end
        checks++;
        if (span() != 35) begin failures++; $display("FAIL single_consecutive: got span %0d expected 35", span()); end
        checks++;
        if (n_last != 1) begin failures++; $display("FAIL single_tlast_count: got %0d expected 1", n_last); end
        checks++;
        if (beat_cyc.size() == 0 || done_cyc - beat_cyc[beat_cyc.size()-1] != 1 || n_done != 1) begin
            failures++; $display("FAIL single_done_timing: got done_cyc=%0d n_done=%0d, expected 1 cycle after last beat, once", done_cyc, n_done);
        end
        checks++;
        if (n_en != 1) begin failures++; $display("FAIL single_bram_en: got %0d expected 1", n_en); end
    endtask

    task automatic test_multi_line();
        bit ok;
        clear_stats();
        pulse_start(0, 2, 1'b1);
        wait_done(ok);
        repeat (3) @(posedge clk);
        checks++;
        if (!ok || n_beats != 108) begin failures++; $display("FAIL multi_beats: got %0d (done=%0b) expected 108", n_beats, ok); end
        checks++;
        if (beat_cyc.size() < 73 || beat_cyc[36] - beat_cyc[35] != GAP || beat_cyc[72] - beat_cyc[71] != GAP) begin
            failures++; $display("FAIL multi_line_gap: got span %0d, expected gaps of %0d cycles", span(), GAP);
        end
        checks++;
        if (span() != 107 + 2 * (GAP - 1)) begin
            failures++; $display("FAIL multi_span: got %0d expected %0d", span(), 107 + 2 * (GAP - 1));
        end
        checks++;
        if (n_last != 1) begin failures++; $display("FAIL multi_tlast_count: got %0d expected 1", n_last); end
        checks++;
        if (n_en != 3) begin failures++; $display("FAIL multi_bram_en: got %0d expected 3", n_en); end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_stats();
        rand_ready = 1'b1;
        pulse_start(0, 2, 1'b1);
        wait_done(ok);
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        checks++;
        if (!ok || n_beats != 108) begin failures++; $display("FAIL bp_beats: got %0d (done=%0b) expected 108", n_beats, ok); end
        checks++;
        if (n_last != 1 || sb.size() != 0) begin
            failures++; $display("FAIL bp_tail: got tlast=%0d left=%0d expected 1 and 0", n_last, sb.size());
        end
    endtask

    task automatic test_illegal();
        bit ok;
        clear_stats();
        pulse_start(10, 9, 1'b1);
        repeat (6) @(posedge clk);
        checks++;
        if (n_err != 1) begin failures++; $display("FAIL illegal_err: got %0d pulses expected 1", n_err); end
        checks++;
        if (n_busy != 0 || n_en != 0 || n_valid != 0 || n_done != 0) begin
            failures++; $display("FAIL illegal_quiet: got busy=%0d en=%0d valid=%0d done=%0d expected all 0", n_busy, n_en, n_valid, n_done);
        end
        clear_stats();
        pulse_start(0, 1, 1'b1);
        repeat (10) @(posedge clk);
        pulse_start(7, 7, 1'b0);
        wait_done(ok);
        repeat (6) @(posedge clk);
        checks++;
        if (!ok || n_beats != 72 || sb.size() != 0) begin
            failures++; $display("FAIL busy_start_ignored: got %0d beats left=%0d expected 72 and 0", n_beats, sb.size());
        end
        checks++;
        if (n_en != 2 || n_err != 0 || n_done != 1) begin
            failures++; $display("FAIL busy_start_side: got en=%0d err=%0d done=%0d expected 2 0 1", n_en, n_err, n_done);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_stats();
        pulse_start(0, 2, 1'b1);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (n_beats >= 56) break;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid_valid: got valid=%0b busy=%0b expected 0 0", m_axis_tvalid, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        repeat (10) @(posedge clk);
        checks++;
        if (n_done != 0) begin failures++; $display("FAIL reset_mid_done: got %0d expected 0", n_done); end

        clear_stats();
        pulse_start(3, 3, 1'b1);
        wait_done(ok);
        repeat (3) @(posedge clk);
        checks++;
        if (!ok || n_beats != 36 || sb.size() != 0 || n_last != 1) begin
            failures++; $display("FAIL post_reset_line3: got %0d beats tlast=%0d expected 36 and 1", n_beats, n_last);
        end

        clear_stats();
        pulse_start(4095, 4095, 1'b1);
        wait_done(ok);
        repeat (10) @(posedge clk);
        checks++;
        if (!ok || n_beats != 36 || n_valid != 36 || sb.size() != 0) begin
            failures++; $display("FAIL top_line_beats: got beats=%0d valid=%0d expected 36 36", n_beats, n_valid);
        end
        checks++;
        if (n_en != 1 || n_done != 1) begin
            failures++; $display("FAIL top_line_nowrap: got en=%0d done=%0d expected 1 1", n_en, n_done);
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_single_line();
        test_multi_line();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
